id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the pipelined RV32I core: registers decoded operands and control from Decode and presents them to Execute. The registered `ex_alu_op`, `ex_fun3`, `ex_fun7`, `ex_op5` drive the ALU control decoder directly. The stage also owns load-use hazard detection, bubble insertion, flush on redirect, and write-back bypass into the captured operands.

## Interface
- `XLEN`, 32: datapath width.
- `CNT_W`, 16: width of the bubble performance counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  Decode holds a real instruction.
- `id_pc`  in  XLEN  instruction PC.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices.
- `id_alu_op`  in  2  00 add (load/store), 01 sub (branch), 10 decode by funct3/funct7.
- `id_fun3`  in  3  instr[14:12].
- `id_fun7`  in  1  instr[30].
- `id_op5`  in  1  instr[5].
- `id_alu_src`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump`  in  1  decoded control.
- `id_result_src`  in  2  00 ALU, 01 memory, 10 PC+4.
- `ex_redirect`  in  1  branch or jump taken in Execute this cycle.
- `wb_reg_write`  in  1  Writeback writes the register file this cycle.
- `wb_rd`  in  5  Writeback destination.
- `wb_data`  in  XLEN  Writeback data.
- `ex_*`  out  (each `id_*` above, same width)  registered copy of the matching input.
- `ex_valid`  out  1  Execute holds a real instruction.
- `stall_fd`  out  1  combinational; hold PC and IF/ID this cycle.
- `flush_fd`  out  1  combinational; clear IF/ID (equals `ex_redirect`).
- `bubble_count`  out  CNT_W  number of bubbles inserted, saturating.

## Operation
- Load-use hazard: `hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- `stall_fd = hz & ~ex_redirect`.
- Priority at each clock edge:
  1. **Flush.** When `ex_redirect` is high, load a bubble. The younger instruction in ID is killed and no stall is raised.
  2. **Stall.** Otherwise, when `hz` is high, load a bubble. Decode holds the same instruction, which re-presents next cycle.
  3. **Advance.** Otherwise, load every `id_*` into `ex_*`, with `ex_valid <= id_valid`.
- Bubble: every `ex_*` output, including `ex_valid`, is loaded with 0. Opcode fields decode as ADD with no side effects.
- Write-back bypass on advance:
  - When `wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1)`, `ex_rs1_data <= wb_data`. The same rule applies to rs2 independently.
  - When `id_rs1 == id_rs2`, both operands take the bypass.
  - x0 is never bypassed.
- `bubble_count` increments on each stall-bubble and each flush-bubble where `id_valid` was high. It saturates at all-ones.
- No memory-to-EX forwarding in this block; that belongs to the forwarding unit downstream.

## Timing
- Latency is 1 cycle from ID inputs to `ex_*`.
- `stall_fd` and `flush_fd` are same-cycle combinational outputs, with no registered path from `id_*`.
- Reset (async assert, sync deassert supplied externally): all `ex_*` = 0, `ex_valid` = 0, `bubble_count` = 0.
- `stall_fd` = 0 during reset because `ex_valid` = 0.
- Reset mid-stall: the stall drops immediately and the held instruction advances on the first edge after release.
- A load-use stall lasts exactly 1 cycle. The bubble clears `ex_mem_read`, so `hz` falls.
- When `ex_redirect` and `hz` are both high, the flush wins and `stall_fd` = 0.
- A back-to-back redirect produces consecutive bubbles.

## Structure
- Shared package `core_pkg` holds:
  - the `ALUOP_*` constants (00/01/10);
  - the `RES_SRC_*` constants (00/01/10);
  - a packed struct `id_ex_t` carrying every pipelined field.
- One natural sub-module, `load_use_detect`: combinational `hz` from the ex/id indices and `ex_mem_read`. The register, bypass, and counter stay in the top module.

## Test plan
- **Advance.** Present `id_valid`=1, `id_alu_op`=10, `id_fun3`=000, `id_fun7`=1, `id_op5`=1, `rs1_data`=5, `rs2_data`=3. Next cycle: `ex_*` equal these values, `ex_valid`=1.
- **Load-use stall.**
  - Stimulus: EX holds `lw x5` (`ex_mem_read`=1, `ex_rd`=5); ID holds `add x6,x5,x1`.
  - Same cycle: `stall_fd`=1.
  - Next cycle: `ex_valid`=0, all controls 0, `bubble_count`=1.
  - Following cycle: the add advances with `stall_fd`=0.
- **Load to x0.** `ex_rd`=0 and `id_rs1`=0 -> `stall_fd`=0, no bubble.
- **Flush over stall.** `ex_redirect`=1 while `hz`=1 -> `stall_fd`=0, `flush_fd`=1, next cycle `ex_valid`=0, `bubble_count` +1.
- **WB bypass.**
  - Stimulus: `wb_reg_write`=1, `wb_rd`=7, `wb_data`=0xDEADBEEF; `id_rs1`=`id_rs2`=7, stale `rs*_data`=0.
  - Response: `ex_rs1_data` = `ex_rs2_data` = 0xDEADBEEF.
  - Repeat with `wb_rd`=0 -> stale value 0 kept.
- **Async reset.**
  - Assert `reset_n`=0 mid-cycle while `ex_valid`=1 -> outputs 0 immediately, without waiting for a clock edge.
  - Counter driven to 0xFFFF then stalled again -> remains 0xFFFF.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Desc     : Shared RV32I core types: ALU-op and result-source encodings, ID/EX record.
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [1:0]        alu_op;
    logic [2:0]        fun3;
    logic              fun7;
    logic              op5;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        result_src;
  } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Desc     : Decode-side inputs, writeback bypass and Execute-side outputs of ID/EX.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [1:0]       id_alu_op;
  logic [2:0]       id_fun3;
  logic             id_fun7, id_op5;
  logic             id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
  logic [1:0]       id_result_src;
  logic             ex_redirect;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [1:0]       ex_alu_op;
  logic [2:0]       ex_fun3;
  logic             ex_fun7, ex_op5;
  logic             ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]       ex_result_src;
  logic             stall_fd, flush_fd;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_fun3, id_fun7, id_op5, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_result_src, ex_redirect,
           wb_reg_write, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_fun3, ex_fun7, ex_op5, ex_alu_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_result_src, stall_fd, flush_fd, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_fun3, id_fun7, id_op5, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_result_src, ex_redirect,
           wb_reg_write, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_fun3, ex_fun7, ex_op5, ex_alu_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_result_src, stall_fd, flush_fd, bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Desc     : Combinational load-use hazard between the load in EX and the instruction in ID.
// Revision : 1.0
// ============================================================================
module load_use_detect (
  input  wire logic       id_valid_i,
  input  wire logic       ex_valid_i,
  input  wire logic       ex_mem_read_i,
  input  wire logic [4:0] ex_rd_i,
  input  wire logic [4:0] id_rs1_i,
  input  wire logic [4:0] id_rs2_i,
  output logic            hz_o
);
  assign hz_o = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Desc     : ID/EX pipeline register with load-use stall, redirect flush and WB bypass.
// Revision : 1.0
// ============================================================================
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  id_ex_stage_if.slave  bus
);

  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             hz, byp1, byp2, bubble_cnt;

  load_use_detect u_load_use_detect (
    .id_valid_i    (bus.id_valid),
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_rd_i       (ex_q.rd),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .hz_o          (hz)
  );

  assign bus.stall_fd = hz & ~bus.ex_redirect;
  assign bus.flush_fd = bus.ex_redirect;

  // x0 is hard-wired zero, so a write-back to it must never leak into an operand.
  assign byp1 = bus.wb_reg_write & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs1);
  assign byp2 = bus.wb_reg_write & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs2);
  assign rs1_fwd = byp1 ? bus.wb_data : bus.id_rs1_data;
  assign rs2_fwd = byp2 ? bus.wb_data : bus.id_rs2_data;

  // A stall implies id_valid, so only flushes of an empty slot go uncounted.
  assign bubble_cnt = bus.ex_redirect ? bus.id_valid : hz;

  always_comb begin
    ex_d  = '0;
    cnt_d = cnt_q;
    if (bus.ex_redirect || hz) begin
      ex_d.alu_op     = ALUOP_ADD;
      ex_d.result_src = RES_SRC_ALU;
      if (bubble_cnt && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d.valid      = bus.id_valid;
      ex_d.pc         = bus.id_pc;
      ex_d.rs1_data   = rs1_fwd;
      ex_d.rs2_data   = rs2_fwd;
      ex_d.imm        = bus.id_imm;
      ex_d.rs1        = bus.id_rs1;
      ex_d.rs2        = bus.id_rs2;
      ex_d.rd         = bus.id_rd;
      ex_d.alu_op     = bus.id_alu_op;
      ex_d.fun3       = bus.id_fun3;
      ex_d.fun7       = bus.id_fun7;
      ex_d.op5        = bus.id_op5;
      ex_d.alu_src    = bus.id_alu_src;
      ex_d.reg_write  = bus.id_reg_write;
      ex_d.mem_read   = bus.id_mem_read;
      ex_d.mem_write  = bus.id_mem_write;
      ex_d.branch     = bus.id_branch;
      ex_d.jump       = bus.id_jump;
      ex_d.result_src = bus.id_result_src;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1_data   = ex_q.rs1_data;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_fun3       = ex_q.fun3;
  assign bus.ex_fun7       = ex_q.fun7;
  assign bus.ex_op5        = ex_q.op5;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_result_src = ex_q.result_src;
  assign bus.bubble_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Desc     : Directed-vector bench for id_ex_stage with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a plain instruction in ID; callers override individual controls afterwards.
  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                           input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid      = v;
    bus.id_pc         = pc;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_rd         = rd;
    bus.id_mem_read   = mr;
    bus.id_rs1_data   = d1;
    bus.id_rs2_data   = d2;
    bus.id_imm        = 32'h0;
    bus.id_alu_op     = mr ? 2'b00 : 2'b10;
    bus.id_fun3       = mr ? 3'b010 : 3'b000;
    bus.id_fun7       = 1'b0;
    bus.id_op5        = ~mr;
    bus.id_alu_src    = mr;
    bus.id_reg_write  = 1'b1;
    bus.id_mem_write  = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_jump       = 1'b0;
    bus.id_result_src = mr ? 2'b01 : 2'b00;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.ex_redirect  = 1'b0;
    bus.wb_reg_write = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'h0;
    set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    #1;
    check_val("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_val("rst_ex_pc", bus.ex_pc, 32'd0);
    check_val("rst_bubbles", {16'd0, bus.bubble_count}, 32'd0);
    check_val("rst_stall", {31'd0, bus.stall_fd}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Advance: ALU R-type with funct7 set
    set_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 32'd5, 32'd3);
    bus.id_fun7 = 1'b1;
    bus.id_imm  = 32'h10;
    #1;
    check_val("adv_stall_comb", {31'd0, bus.stall_fd}, 32'd0);
    tick();
    check_val("adv_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_val("adv_alu_op", {30'd0, bus.ex_alu_op}, 32'd2);
    check_val("adv_fun3", {29'd0, bus.ex_fun3}, 32'd0);
    check_val("adv_fun7_op5", {30'd0, bus.ex_fun7, bus.ex_op5}, 32'd3);
    check_val("adv_rs1_data", bus.ex_rs1_data, 32'd5);
    check_val("adv_rs2_data", bus.ex_rs2_data, 32'd3);
    check_val("adv_pc", bus.ex_pc, 32'h100);
    check_val("adv_imm", bus.ex_imm, 32'h10);
    check_val("adv_rd", {27'd0, bus.ex_rd}, 32'd3);

    // Load-use: lw x5 then add x6,x5,x1
    set_instr(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 32'h40, 32'h0);
    tick();
    check_val("lw_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
    check_val("lw_result_src", {30'd0, bus.ex_result_src}, 32'd1);
    set_instr(1'b1, 32'h108, 5'd5, 5'd1, 5'd6, 1'b0, 32'h11, 32'h22);
    #1;
    check_val("lu_stall", {31'd0, bus.stall_fd}, 32'd1);
    check_val("lu_flush", {31'd0, bus.flush_fd}, 32'd0);
    tick();
    check_val("lu_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_val("lu_bub_ctrl", {26'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op,
                              bus.ex_result_src}, 32'd0);
    check_val("lu_bub_rd", {27'd0, bus.ex_rd}, 32'd0);
    check_val("lu_bub_count", {16'd0, bus.bubble_count}, 32'd1);
    check_val("lu_stall_drop", {31'd0, bus.stall_fd}, 32'd0);
    tick();
    check_val("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_val("lu_add_rd", {27'd0, bus.ex_rd}, 32'd6);
    check_val("lu_add_pc", bus.ex_pc, 32'h108);

    // Load to x0 never stalls
    set_instr(1'b1, 32'h10C, 5'd2, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    tick();
    set_instr(1'b1, 32'h110, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0, 32'h0);
    #1;
    check_val("x0_stall", {31'd0, bus.stall_fd}, 32'd0);
    tick();
    check_val("x0_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_val("x0_count", {16'd0, bus.bubble_count}, 32'd1);

    // Flush wins over a pending load-use stall
    set_instr(1'b1, 32'h114, 5'd2, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    tick();
    set_instr(1'b1, 32'h118, 5'd5, 5'd1, 5'd6, 1'b0, 32'h0, 32'h0);
    bus.ex_redirect = 1'b1;
    #1;
    check_val("fl_stall", {31'd0, bus.stall_fd}, 32'd0);
    check_val("fl_flush", {31'd0, bus.flush_fd}, 32'd1);
    tick();
    check_val("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_val("fl_count", {16'd0, bus.bubble_count}, 32'd2);
    tick();
    check_val("fl_b2b_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_val("fl_b2b_count", {16'd0, bus.bubble_count}, 32'd3);
    bus.id_valid = 1'b0;
    tick();
    check_val("fl_empty_count", {16'd0, bus.bubble_count}, 32'd3);
    bus.ex_redirect = 1'b0;

    // WB bypass into both operands, one operand, and never for x0
    set_instr(1'b1, 32'h200, 5'd7, 5'd7, 5'd8, 1'b0, 32'h0, 32'h0);
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = 5'd7;
    bus.wb_data      = 32'hDEADBEEF;
    tick();
    check_val("byp_rs1", bus.ex_rs1_data, 32'hDEADBEEF);
    check_val("byp_rs2", bus.ex_rs2_data, 32'hDEADBEEF);
    set_instr(1'b1, 32'h204, 5'd9, 5'd7, 5'd8, 1'b0, 32'h55, 32'h66);
    tick();
    check_val("byp_only_rs1_keep", bus.ex_rs1_data, 32'h55);
    check_val("byp_only_rs2_fwd", bus.ex_rs2_data, 32'hDEADBEEF);
    set_instr(1'b1, 32'h208, 5'd0, 5'd0, 5'd8, 1'b0, 32'h0, 32'h0);
    bus.wb_rd = 5'd0;
    tick();
    check_val("byp_x0_rs1", bus.ex_rs1_data, 32'h0);
    check_val("byp_x0_rs2", bus.ex_rs2_data, 32'h0);
    set_instr(1'b1, 32'h20C, 5'd7, 5'd7, 5'd8, 1'b0, 32'h13, 32'h14);
    bus.wb_rd        = 5'd7;
    bus.wb_reg_write = 1'b0;
    tick();
    check_val("byp_nowr_rs1", bus.ex_rs1_data, 32'h13);
    check_val("byp_nowr_rs2", bus.ex_rs2_data, 32'h14);

    // Async reset in the middle of a load-use stall
    set_instr(1'b1, 32'h300, 5'd2, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    tick();
    set_instr(1'b1, 32'h304, 5'd1, 5'd5, 5'd6, 1'b0, 32'h0, 32'h0);
    #1;
    check_val("ar_stall_pre", {31'd0, bus.stall_fd}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("ar_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_val("ar_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    check_val("ar_pc", bus.ex_pc, 32'd0);
    check_val("ar_count", {16'd0, bus.bubble_count}, 32'd0);
    check_val("ar_stall", {31'd0, bus.stall_fd}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check_val("ar_adv_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_val("ar_adv_pc", bus.ex_pc, 32'h304);

    // Bubble counter saturation
    bus.ex_redirect = 1'b1;
    repeat (65535) tick();
    check_val("sat_reach", {16'd0, bus.bubble_count}, 32'h0000FFFF);
    tick();
    check_val("sat_flush_hold", {16'd0, bus.bubble_count}, 32'h0000FFFF);
    bus.ex_redirect = 1'b0;
    set_instr(1'b1, 32'h400, 5'd2, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    tick();
    set_instr(1'b1, 32'h404, 5'd5, 5'd1, 5'd6, 1'b0, 32'h0, 32'h0);
    #1;
    check_val("sat_stall", {31'd0, bus.stall_fd}, 32'd1);
    tick();
    check_val("sat_stall_hold", {16'd0, bus.bubble_count}, 32'h0000FFFF);
    check_val("sat_bub_valid", {31'd0, bus.ex_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
